// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures instruction word and PC+4 when enabled.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: en=0 holds all fields; clr drops valid (kept low on a load with clr).
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] inst_d,
    input  logic [31:0] pc_plus4_d,
    output logic [31:0] inst,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            inst     <= NOP_INST;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (en) begin
            inst     <= inst_d;
            pc_plus4 <= pc_plus4_d;
            valid    <= ~clr;
        end else if (clr) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives imem, fills IF/ID, drains and halts at end of program.
// Latency: word at pc appears on if_id_inst one cycle later.
// Backpressure: stall holds pc and IF/ID; redirect wins over stall and squashes IF/ID.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          INST_MEM_SIZE = 64,
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter int          DRAIN_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_END = 32'(4 * INST_MEM_SIZE);
    localparam int          CW      = $clog2(DRAIN_CYCLES + 2);

    state_t          state, state_nxt;
    logic [31:0]     pc_nxt;
    logic [31:0]     pc_plus4;
    logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
    logic            ifid_en, ifid_clr;
    logic            redir_aligned;

    assign pc_plus4      = pc + PC_INC;
    assign redir_aligned = (redirect_pc[1:0] == 2'b00);
    assign imem_addr     = pc;
    assign halted        = (state == ST_HALT);
    assign fault         = (state == ST_FAULT);

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drain_cnt_nxt = drain_cnt;
        ifid_en       = 1'b0;
        ifid_clr      = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    if (!redir_aligned) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        pc_nxt = redirect_pc;
                        if (redirect_pc >= MEM_END) begin
                            state_nxt     = ST_DRAIN;
                            drain_cnt_nxt = CW'(DRAIN_CYCLES);
                        end
                    end
                end else if (stall) begin
                    ifid_clr = flush;
                end else begin
                    ifid_en  = 1'b1;
                    ifid_clr = flush;
                    pc_nxt   = pc_plus4;
                    // last word is latched; pc moves past memory and the pipe drains
                    if (pc_plus4 >= MEM_END) begin
                        state_nxt     = ST_DRAIN;
                        drain_cnt_nxt = CW'(DRAIN_CYCLES);
                    end
                end
            end
            ST_DRAIN: begin
                if (redirect && !redir_aligned) begin
                    state_nxt = ST_FAULT;
                end else if (redirect && (redirect_pc < MEM_END)) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = redirect_pc;
                end else begin
                    drain_cnt_nxt = (drain_cnt == '0) ? '0 : drain_cnt - CW'(1);
                    if (drain_cnt <= CW'(1)) state_nxt = ST_HALT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            drain_cnt   <= '0;
            fetch_count <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (ifid_en && !ifid_clr && (fetch_count != 32'hFFFF_FFFF))
                fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .reset      (reset),
        .en         (ifid_en),
        .clr        (ifid_clr),
        .inst_d     (imem_inst),
        .pc_plus4_d (pc_plus4),
        .inst       (if_id_inst),
        .pc_plus4   (if_id_pc_plus4),
        .valid      (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench: vector table on an 8-word program, plus fault and loop-back sequences.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, stall, flush, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] imem_addr, imem_inst, pc, if_id_inst, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, halted, fault;

    logic [31:0] s_imem_addr, s_imem_inst, s_pc, s_inst, s_pp4, s_count;
    logic        s_valid, s_halted, s_fault;

    logic [31:0] mem8 [8];
    logic [31:0] mem4 [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.INST_MEM_SIZE(8), .RESET_PC(32'h0), .DRAIN_CYCLES(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_inst(imem_inst), .pc(pc),
        .if_id_inst(if_id_inst), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .halted(halted), .fault(fault), .fetch_count(fetch_count)
    );

    fetch_ctrl #(.INST_MEM_SIZE(4), .RESET_PC(32'h0), .DRAIN_CYCLES(4)) u_small (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(s_imem_addr), .imem_inst(s_imem_inst), .pc(s_pc),
        .if_id_inst(s_inst), .if_id_pc_plus4(s_pp4), .if_id_valid(s_valid),
        .halted(s_halted), .fault(s_fault), .fetch_count(s_count)
    );

    always_comb begin
        imem_inst = 32'h0;
        if (imem_addr[31:2] < 30'd8) imem_inst = mem8[imem_addr[4:2]];
        s_imem_inst = 32'h0;
        if (s_imem_addr[31:2] < 30'd4) s_imem_inst = mem4[s_imem_addr[3:2]];
    end

    typedef struct {
        logic        rst, st, sl, fl, rd;
        logic [31:0] rpc;
        logic [31:0] pc, inst, pp4;
        logic        vld, hlt;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic st, logic sl, logic fl, logic rd,
                                logic [31:0] rpc, logic [31:0] epc, logic [31:0] einst,
                                logic [31:0] epp4, logic evld, logic ehlt, logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.st = st; v.sl = sl; v.fl = fl; v.rd = rd; v.rpc = rpc;
        v.pc = epc; v.inst = einst; v.pp4 = epp4; v.vld = evld; v.hlt = ehlt; v.cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic st, input logic sl, input logic fl,
                       input logic rd, input logic [31:0] rpc);
        reset = rst; start = st; stall = sl; flush = fl; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem8[i] = 32'h2008_0001 + 32'(i);
        mem4[0] = 32'h8C08_0000;
        mem4[1] = 32'h8C09_0004;
        mem4[2] = 32'h0109_5020;
        mem4[3] = 32'h1000_FFFC;
        reset = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // clean 8-word run, drain, halt
        tbl.push_back(mk(1,0,0,0,0,0,     'h00, 'h0,        'h00, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0,0,     'h00, 'h0,        'h00, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0,0,0,     'h04, 'h20080001, 'h04, 1, 0, 1));
        tbl.push_back(mk(0,0,0,0,0,0,     'h08, 'h20080002, 'h08, 1, 0, 2));
        tbl.push_back(mk(0,0,0,0,0,0,     'h0C, 'h20080003, 'h0C, 1, 0, 3));
        tbl.push_back(mk(0,0,0,0,0,0,     'h10, 'h20080004, 'h10, 1, 0, 4));
        tbl.push_back(mk(0,0,0,0,0,0,     'h14, 'h20080005, 'h14, 1, 0, 5));
        tbl.push_back(mk(0,0,0,0,0,0,     'h18, 'h20080006, 'h18, 1, 0, 6));
        tbl.push_back(mk(0,0,0,0,0,0,     'h1C, 'h20080007, 'h1C, 1, 0, 7));
        tbl.push_back(mk(0,0,0,0,0,0,     'h20, 'h20080008, 'h20, 1, 0, 8));
        tbl.push_back(mk(0,0,0,0,0,0,     'h20, 'h20080008, 'h20, 0, 0, 8));
        tbl.push_back(mk(0,0,1,1,0,0,     'h20, 'h20080008, 'h20, 0, 0, 8));
        tbl.push_back(mk(0,0,0,0,0,0,     'h20, 'h20080008, 'h20, 0, 0, 8));
        tbl.push_back(mk(0,0,0,0,0,0,     'h20, 'h20080008, 'h20, 0, 1, 8));
        tbl.push_back(mk(0,1,0,0,0,0,     'h20, 'h20080008, 'h20, 0, 1, 8));
        // stall, stall+flush, redirect under stall, flush on advance
        tbl.push_back(mk(1,0,0,0,0,0,     'h00, 'h0,        'h00, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0,0,     'h00, 'h0,        'h00, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0,0,0,     'h04, 'h20080001, 'h04, 1, 0, 1));
        tbl.push_back(mk(0,0,0,0,0,0,     'h08, 'h20080002, 'h08, 1, 0, 2));
        tbl.push_back(mk(0,0,0,0,0,0,     'h0C, 'h20080003, 'h0C, 1, 0, 3));
        tbl.push_back(mk(0,0,1,0,0,0,     'h0C, 'h20080003, 'h0C, 1, 0, 3));
        tbl.push_back(mk(0,0,1,0,0,0,     'h0C, 'h20080003, 'h0C, 1, 0, 3));
        tbl.push_back(mk(0,0,1,1,0,0,     'h0C, 'h20080003, 'h0C, 0, 0, 3));
        tbl.push_back(mk(0,0,0,0,0,0,     'h10, 'h20080004, 'h10, 1, 0, 4));
        tbl.push_back(mk(0,0,0,0,0,0,     'h14, 'h20080005, 'h14, 1, 0, 5));
        tbl.push_back(mk(0,0,1,0,1,'h04,  'h04, 'h20080005, 'h14, 0, 0, 5));
        tbl.push_back(mk(0,0,0,0,0,0,     'h08, 'h20080002, 'h08, 1, 0, 6));
        tbl.push_back(mk(0,0,0,1,0,0,     'h0C, 'h20080003, 'h0C, 0, 0, 6));
        // run into DRAIN, then reset mid-drain and restart
        tbl.push_back(mk(0,0,0,0,0,0,     'h10, 'h20080004, 'h10, 1, 0, 7));
        tbl.push_back(mk(0,0,0,0,0,0,     'h14, 'h20080005, 'h14, 1, 0, 8));
        tbl.push_back(mk(0,0,0,0,0,0,     'h18, 'h20080006, 'h18, 1, 0, 9));
        tbl.push_back(mk(0,0,0,0,0,0,     'h1C, 'h20080007, 'h1C, 1, 0, 10));
        tbl.push_back(mk(0,0,0,0,0,0,     'h20, 'h20080008, 'h20, 1, 0, 11));
        tbl.push_back(mk(0,0,0,0,0,0,     'h20, 'h20080008, 'h20, 0, 0, 11));
        tbl.push_back(mk(1,0,0,0,0,0,     'h00, 'h0,        'h00, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0,0,     'h00, 'h0,        'h00, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0,0,0,     'h04, 'h20080001, 'h04, 1, 0, 1));
        // aligned redirect past memory end goes straight to DRAIN
        tbl.push_back(mk(0,0,0,0,1,'h40,  'h40, 'h20080001, 'h04, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0,0,0,     'h40, 'h20080001, 'h04, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0,0,0,     'h40, 'h20080001, 'h04, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0,0,0,     'h40, 'h20080001, 'h04, 0, 0, 1));
        tbl.push_back(mk(0,0,0,0,0,0,     'h40, 'h20080001, 'h04, 0, 1, 1));

        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].sl, tbl[i].fl, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("r%0d pc", i),        pc,                    tbl[i].pc);
            chk($sformatf("r%0d imem_addr", i), imem_addr,             tbl[i].pc);
            chk($sformatf("r%0d inst", i),      if_id_inst,            tbl[i].inst);
            chk($sformatf("r%0d pc_plus4", i),  if_id_pc_plus4,        tbl[i].pp4);
            chk($sformatf("r%0d valid", i),     32'(if_id_valid),      32'(tbl[i].vld));
            chk($sformatf("r%0d halted", i),    32'(halted),           32'(tbl[i].hlt));
            chk($sformatf("r%0d fault", i),     32'(fault),            32'h0);
            chk($sformatf("r%0d count", i),     fetch_count,           tbl[i].cnt);
        end

        // misaligned redirect: sticky fault, pc frozen until reset
        cyc(1,0,0,0,0,0);
        cyc(0,1,0,0,0,0);
        cyc(0,0,0,0,0,0);
        cyc(0,0,0,0,0,0);
        chk("flt pre pc", pc, 32'h08);
        cyc(0,0,0,0,1,32'h06);
        chk("flt fault",  32'(fault),       32'h1);
        chk("flt valid",  32'(if_id_valid), 32'h0);
        chk("flt pc",     pc,               32'h08);
        for (int k = 0; k < 3; k++) begin
            cyc(0,1,0,0,1,32'h0);
            chk($sformatf("flt hold%0d fault", k), 32'(fault), 32'h1);
            chk($sformatf("flt hold%0d pc", k),    pc,          32'h08);
            chk($sformatf("flt hold%0d valid", k), 32'(if_id_valid), 32'h0);
        end
        cyc(1,0,0,0,0,0);
        chk("flt rst fault", 32'(fault), 32'h0);
        chk("flt rst pc",    pc,         32'h0);

        // 4-word program: loop-back redirect on the 2nd DRAIN cycle
        cyc(0,1,0,0,0,0);
        for (int k = 0; k < 4; k++) cyc(0,0,0,0,0,0);
        chk("lb last pc",    s_pc,             32'h10);
        chk("lb last inst",  s_inst,           32'h1000_FFFC);
        chk("lb last valid", 32'(s_valid),     32'h1);
        cyc(0,0,0,0,0,0);
        chk("lb d1 valid",   32'(s_valid),     32'h0);
        chk("lb d1 pc",      s_pc,             32'h10);
        cyc(0,0,0,0,1,32'h0);
        chk("lb d2 pc",      s_pc,             32'h0);
        chk("lb d2 valid",   32'(s_valid),     32'h0);
        chk("lb d2 halted",  32'(s_halted),    32'h0);
        cyc(0,0,0,0,0,0);
        chk("lb rerun pc",   s_pc,             32'h04);
        chk("lb rerun inst", s_inst,           32'h8C08_0000);
        chk("lb rerun valid",32'(s_valid),     32'h1);
        chk("lb rerun count",s_count,          32'd5);
        cyc(0,0,0,0,0,0);
        cyc(0,0,0,0,0,0);
        chk("lb later pc",     s_pc,          32'h0C);
        chk("lb later halted", 32'(s_halted), 32'h0);
        chk("lb later fault",  32'(s_fault),  32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
